// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared types and constants for the serial program loader:
//               frame FSM state encoding, sync byte, error codes and the
//               word-count bound check.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    // Frame parser states
    typedef enum logic [2:0] {
        S_SYNC   = 3'd0,
        S_CNT_H  = 3'd1,
        S_CNT_L  = 3'd2,
        S_DATA_H = 3'd3,
        S_DATA_L = 3'd4,
        S_CSUM   = 3'd5,
        S_ERR    = 3'd6
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_FRAME = 2'b01;
    localparam logic [1:0] ERR_CSUM  = 2'b10;
    localparam logic [1:0] ERR_CNT   = 2'b11;

    // True when a frame announces more words than the memory can hold.
    function automatic logic count_exceeds(input logic [15:0] cnt, input int addr_w);
        return ({16'h0000, cnt} > (32'd1 << addr_w));
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_byte
// Description : 8N1 UART byte receiver. Two-flop synchronizer on rx, start
//               bit glitch rejection at half a bit time, LSB-first data
//               sampling and stop-bit check. byte_valid pulses for one cycle
//               on a good stop bit, frame_err on a bad one.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int                 c_CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_M1 = c_CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    rx_state_t          r_state, w_state_nxt;
    logic               r_sync1, r_sync2, r_prev;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]         r_bit, w_bit_nxt;
    logic [7:0]         r_shift, w_shift_nxt;
    logic               r_valid, w_valid_nxt;
    logic               r_ferr, w_ferr_nxt;

    // Synchronize rx and keep one extra stage for falling-edge detection;
    // all stages preset to the idle (high) level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Receiver state, bit timer, bit index, shift register and pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    // Bit timing: half a bit to the start-bit centre, then one full bit per sample.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (r_prev && !r_sync2) begin
                    w_state_nxt = RX_START;
                    w_cnt_nxt   = '0;
                end
            end
            RX_START: begin
                if (r_cnt == c_HALF_M1) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    // A line already back high at mid start bit was a glitch.
                    w_state_nxt = r_sync2 ? RX_IDLE : RX_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (r_cnt == c_FULL_M1) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_sync2, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 1'b1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = RX_STOP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (r_cnt == c_FULL_M1) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = RX_IDLE;
                    w_valid_nxt = r_sync2;
                    w_ferr_nxt  = !r_sync2;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = RX_IDLE;
        endcase
    end

    assign byte_valid = r_valid;
    assign byte_data  = r_shift;
    assign frame_err  = r_ferr;

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Serial bootloader. Parses A5 / CNT_H / CNT_L / words / CSUM
//               frames from a UART line, writes big-endian 16-bit words to
//               consecutive instruction-memory addresses and holds the core
//               while a load is running or after a failed load.
//               Optional inter-byte timeout: define LOADER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 12,
    parameter int TIMEOUT_CYC  = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data,
    output logic              mem_wren,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    logic       w_byte_valid;
    logic [7:0] w_byte_data;
    logic       w_frame_err;
    logic       w_timeout;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .byte_valid (w_byte_valid),
        .byte_data  (w_byte_data),
        .frame_err  (w_frame_err)
    );

    loader_state_t     r_state, w_state_nxt;
    logic [15:0]       r_cnt, w_cnt_nxt;
    logic [7:0]        r_hi, w_hi_nxt;
    logic [ADDR_W:0]   r_idx, w_idx_nxt;
    logic [7:0]        r_csum, w_csum_nxt;
    logic [1:0]        r_pend, w_pend_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [15:0]       r_mem_data, w_mem_data_nxt;
    logic              r_mem_wren, w_mem_wren_nxt;
    logic              r_cpu_hold, w_cpu_hold_nxt;
    logic              r_done, w_done_nxt;
    logic              r_err, w_err_nxt;
    logic [1:0]        r_err_code, w_err_code_nxt;

    logic [15:0]       w_cnt_full;
    logic [ADDR_W:0]   w_idx_inc;

    assign w_cnt_full = {r_cnt[15:8], w_byte_data};
    assign w_idx_inc  = r_idx + 1'b1;

`ifdef LOADER_TIMEOUT_EN
    localparam int              c_TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYC - 1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              w_to_active;

    assign w_to_active = (r_state != S_SYNC) && (r_state != S_ERR);

    // Inter-byte watchdog: restarts on every byte, idle outside a frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt <= '0;
        end else if (w_byte_valid || !w_to_active) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != c_TO_LAST) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = w_to_active && !w_byte_valid && (r_to_cnt == c_TO_LAST);
`else
    // No watchdog: a stalled frame waits indefinitely (a negative budget is
    // meaningless, so this is always 0).
    assign w_timeout = (TIMEOUT_CYC < 0);
`endif

    // Frame FSM state and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_SYNC;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_idx      <= '0;
            r_csum     <= '0;
            r_pend     <= ERR_NONE;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_mem_wren <= 1'b0;
            r_cpu_hold <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_hi       <= w_hi_nxt;
            r_idx      <= w_idx_nxt;
            r_csum     <= w_csum_nxt;
            r_pend     <= w_pend_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_mem_data <= w_mem_data_nxt;
            r_mem_wren <= w_mem_wren_nxt;
            r_cpu_hold <= w_cpu_hold_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_err_code <= w_err_code_nxt;
        end
    end

    // Frame parsing: errors pre-empt byte handling and detour through S_ERR.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_hi_nxt       = r_hi;
        w_idx_nxt      = r_idx;
        w_csum_nxt     = r_csum;
        w_pend_nxt     = r_pend;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_data_nxt = r_mem_data;
        w_mem_wren_nxt = 1'b0;
        w_cpu_hold_nxt = r_cpu_hold;
        w_done_nxt     = r_done;
        w_err_nxt      = r_err;
        w_err_code_nxt = r_err_code;

        if (w_timeout) begin
            w_pend_nxt  = ERR_CNT;
            w_state_nxt = S_ERR;
        end else if (w_frame_err && (r_state != S_SYNC) && (r_state != S_ERR)) begin
            w_pend_nxt  = ERR_FRAME;
            w_state_nxt = S_ERR;
        end else begin
            case (r_state)
                S_SYNC: begin
                    if (w_byte_valid && (w_byte_data == SYNC_BYTE)) begin
                        w_cpu_hold_nxt = 1'b1;
                        w_done_nxt     = 1'b0;
                        w_err_nxt      = 1'b0;
                        w_err_code_nxt = ERR_NONE;
                        w_idx_nxt      = '0;
                        w_csum_nxt     = '0;
                        w_state_nxt    = S_CNT_H;
                    end
                end
                S_CNT_H: begin
                    if (w_byte_valid) begin
                        w_cnt_nxt   = {w_byte_data, 8'h00};
                        w_state_nxt = S_CNT_L;
                    end
                end
                S_CNT_L: begin
                    if (w_byte_valid) begin
                        w_cnt_nxt = w_cnt_full;
                        if (count_exceeds(w_cnt_full, ADDR_W)) begin
                            w_pend_nxt  = ERR_CNT;
                            w_state_nxt = S_ERR;
                        end else if (w_cnt_full == 16'h0000) begin
                            w_state_nxt = S_CSUM;
                        end else begin
                            w_state_nxt = S_DATA_H;
                        end
                    end
                end
                S_DATA_H: begin
                    if (w_byte_valid) begin
                        w_hi_nxt    = w_byte_data;
                        w_csum_nxt  = r_csum ^ w_byte_data;
                        w_state_nxt = S_DATA_L;
                    end
                end
                S_DATA_L: begin
                    if (w_byte_valid) begin
                        w_csum_nxt     = r_csum ^ w_byte_data;
                        w_mem_data_nxt = {r_hi, w_byte_data};
                        w_mem_addr_nxt = r_idx[ADDR_W-1:0];
                        w_mem_wren_nxt = 1'b1;
                        w_idx_nxt      = w_idx_inc;
                        // Count is bounded by 2**ADDR_W, so the index never wraps.
                        w_state_nxt    = (32'(w_idx_inc) == 32'(r_cnt)) ? S_CSUM : S_DATA_H;
                    end
                end
                S_CSUM: begin
                    if (w_byte_valid) begin
                        if (w_byte_data == r_csum) begin
                            w_done_nxt     = 1'b1;
                            w_cpu_hold_nxt = 1'b0;
                            w_state_nxt    = S_SYNC;
                        end else begin
                            w_pend_nxt  = ERR_CSUM;
                            w_state_nxt = S_ERR;
                        end
                    end
                end
                S_ERR: begin
                    // Hold stays asserted so a partial image never runs.
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = r_pend;
                    w_state_nxt    = S_SYNC;
                end
                default: w_state_nxt = S_SYNC;
            endcase
        end
    end

    assign mem_addr = r_mem_addr;
    assign mem_data = r_mem_data;
    assign mem_wren = r_mem_wren;
    assign cpu_hold = r_cpu_hold;
    assign done     = r_done;
    assign err      = r_err;
    assign err_code = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Self-checking bench for program_loader. Frames are built by
//               the bench; expected writes and status come from what the
//               frame contains (word list, count, checksum corruption).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_program_loader;

    localparam int CPB = 4;
    localparam int AW  = 4;
    localparam int TO  = 200;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx  = 1'b1;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_data;
    logic          mem_wren;
    logic          cpu_hold;
    logic          done;
    logic          err;
    logic [1:0]    err_code;

    program_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (AW),
        .TIMEOUT_CYC  (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_wren (mem_wren),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Every cycle with mem_wren high is one recorded write; a stretched
    // strobe therefore shows up as an extra write.
    logic [AW+15:0] got_q[$];
    always @(negedge clk) begin
        if (mem_wren === 1'b1) got_q.push_back({mem_addr, mem_data});
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB * int'($urandom_range(1, 3))) @(negedge clk);
    endtask

    task automatic expect_result(input string tag, input logic [AW+15:0] exp_w[$],
                                 input bit exp_done, input bit exp_err,
                                 input logic [1:0] exp_code, input bit exp_hold);
        repeat (12) @(negedge clk);
        check($sformatf("%s.nwr", tag), 32'(got_q.size()), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < got_q.size(); i++)
            check($sformatf("%s.wr%0d", tag, i), 32'(got_q[i]), 32'(exp_w[i]));
        check($sformatf("%s.done", tag), 32'(done), 32'(exp_done));
        check($sformatf("%s.err", tag), 32'(err), 32'(exp_err));
        check($sformatf("%s.code", tag), 32'(err_code), 32'(exp_code));
        check($sformatf("%s.hold", tag), 32'(cpu_hold), 32'(exp_hold));
        got_q.delete();
    endtask

    // Model: every word lands at its position in the list; the frame
    // succeeds exactly when the checksum is left uncorrupted.
    task automatic send_frame(input string tag, input logic [15:0] words[$],
                              input logic [7:0] flip, input logic [7:0] junk[$]);
        logic [7:0]     cs;
        logic [15:0]    n;
        logic [15:0]    w;
        logic [AW+15:0] exp_w[$];
        cs = 8'h00;
        n  = 16'(words.size());
        foreach (junk[j]) send_byte(junk[j], 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(n[15:8], 1'b1);
        send_byte(n[7:0], 1'b1);
        foreach (words[i]) begin
            w = words[i];
            send_byte(w[15:8], 1'b1);
            send_byte(w[7:0], 1'b1);
            cs = cs ^ w[15:8] ^ w[7:0];
            exp_w.push_back({AW'(i), w});
        end
        send_byte(cs ^ flip, 1'b1);
        expect_result(tag, exp_w, flip == 8'h00, flip != 8'h00,
                      (flip == 8'h00) ? 2'b00 : 2'b10, flip != 8'h00);
    endtask

    task automatic send_overflow(input string tag, input int cnt);
        logic [15:0]    n;
        logic [AW+15:0] none[$];
        n = 16'(cnt);
        send_byte(8'hA5, 1'b1);
        send_byte(n[15:8], 1'b1);
        send_byte(n[7:0], 1'b1);
        expect_result(tag, none, 1'b0, 1'b1, 2'b11, 1'b1);
    endtask

    logic [15:0] words[$];
    logic [7:0]  junk[$];
    logic [7:0]  b;
    logic [7:0]  flip;
    int          k;
    int          nj;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset.outs", 32'({mem_addr, mem_data, mem_wren, cpu_hold, done, err, err_code}), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // 1: two words, correct checksum
        words = '{16'h1234, 16'hABCD};
        junk.delete();
        send_frame("t1", words, 8'h00, junk);

        // 2: same frame, checksum off by one bit
        send_frame("t2", words, 8'h01, junk);

        // 3: junk then an empty frame
        words.delete();
        junk = '{8'h3C, 8'hFF};
        send_frame("t3", words, 8'h00, junk);

        // 4: count overflow, then a valid frame clears the error
        send_overflow("t4", 17);
        words = '{16'hBEEF};
        junk.delete();
        send_frame("t4ok", words, 8'h00, junk);

        // 5: framing error on the first data byte, then an idle glitch
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h12, 1'b0);
        words.delete();
        begin
            logic [AW+15:0] none[$];
            expect_result("t5", none, 1'b0, 1'b1, 2'b01, 1'b1);
        end
        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (60) @(negedge clk);
        check("t5.glitch.code", 32'(err_code), 32'(2'b01));
        check("t5.glitch.nwr", 32'(got_q.size()), 32'd0);
        words = '{16'h0F0F, 16'h55AA, 16'h0001};
        send_frame("t5ok", words, 8'h00, junk);

        // Randomized frames
        for (int f = 0; f < 6; f++) begin
            words.delete();
            junk.delete();
            k = int'($urandom_range(0, 16));
            for (int i = 0; i < k; i++) words.push_back(16'($urandom));
            nj = int'($urandom_range(0, 2));
            for (int j = 0; j < nj; j++) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h3C;
                junk.push_back(b);
            end
            flip = ($urandom_range(0, 2) == 0) ? 8'(8'h01 << $urandom_range(0, 7)) : 8'h00;
            send_frame($sformatf("rnd%0d", f), words, flip, junk);
        end
        send_overflow("rnd_ovf", int'($urandom_range(17, 1000)));
        words = '{16'h0000};
        send_frame("rnd_rec", words, 8'h00, junk);

        // 6: reset mid-frame after the first word was written
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        repeat (8) @(negedge clk);
        check("t6.nwr", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) check("t6.wr0", 32'(got_q[0]), 32'({4'h0, 16'h1234}));
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t6.rst.outs", 32'({mem_addr, mem_data, mem_wren, cpu_hold, done, err, err_code}), 32'd0);
        rst = 1'b1;
        repeat (80) @(negedge clk);
        check("t6.after.nwr", 32'(got_q.size()), 32'd1);
        check("t6.after.hold", 32'(cpu_hold), 32'd0);
        got_q.delete();

        // Stall after A5 00
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (150) @(negedge clk);
        check("stall.early.err", 32'(err), 32'd0);
        check("stall.early.hold", 32'(cpu_hold), 32'd1);
        repeat (80) @(negedge clk);
`ifdef LOADER_TIMEOUT_EN
        check("stall.to.err", 32'(err), 32'd1);
        check("stall.to.code", 32'(err_code), 32'(2'b11));
        check("stall.to.hold", 32'(cpu_hold), 32'd1);
`else
        check("stall.wait.err", 32'(err), 32'd0);
        check("stall.wait.done", 32'(done), 32'd0);
        check("stall.wait.hold", 32'(cpu_hold), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
